// File: rtl/blade_ignition_seq.sv
`default_nettype none
// ============================================================================
// Module      : blade_ignition_seq
// Description : Blade ignition / retraction animator and emitter colour
//               driver. The lit length walks toward the configured length in
//               STEP_CM increments every TICK_DIV cycles while enabled, and
//               walks back to zero when disabled or out of power. The emitter
//               colour halves on alternate FLICKER_DIV-cycle windows while the
//               low-power warning is raised in the ON state.
// Ports       : clk, rst            clock, asynchronous active-high reset
//               on_i                saber on request
//               len_in_i/len_dec_i  configured length (metres / centimetres)
//               r_i/g_i/b_i         configured colour
//               power_level_i       remaining power (0 = exhausted)
//               power_warn_i        low-power warning
//               lit_len_o           currently lit length in cm (0..363)
//               r_o/g_o/b_o         emitter colour
//               state_o             OFF=0, IGNITE=1, ON=2, RETRACT=3
//               ready_o             high while state is ON
// Revision    : 1.0 - initial release
// ============================================================================
module blade_ignition_seq #(
    parameter int STEP_CM     = 8,
    parameter int TICK_DIV    = 4,
    parameter int FLICKER_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       on_i,
    input  logic [1:0] len_in_i,
    input  logic [5:0] len_dec_i,
    input  logic [7:0] r_i,
    input  logic [7:0] g_i,
    input  logic [7:0] b_i,
    input  logic [7:0] power_level_i,
    input  logic       power_warn_i,
    output logic [8:0] lit_len_o,
    output logic [7:0] r_o,
    output logic [7:0] g_o,
    output logic [7:0] b_o,
    output logic [1:0] state_o,
    output logic       ready_o
);

    localparam int         TW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int         FW     = (FLICKER_DIV > 1) ? $clog2(FLICKER_DIV) : 1;
    localparam logic [8:0] C_STEP = 9'(STEP_CM);

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_IGNITE  = 2'd1,
        ST_ON      = 2'd2,
        ST_RETRACT = 2'd3
    } state_t;

    state_t          r_state,    w_state_nxt;
    logic [8:0]      r_lit,      w_lit_nxt;
    logic [TW-1:0]   r_tick_cnt, w_tick_cnt_nxt;
    logic [FW-1:0]   r_flk_cnt,  w_flk_cnt_nxt;
    logic            r_dim,      w_dim_nxt;
    logic [7:0]      r_r, r_g, r_b;
    logic [7:0]      w_r_nxt, w_g_nxt, w_b_nxt;
    logic            r_ready;

    logic [8:0]      w_target;
    logic            w_en;
    logic            w_tick;
    logic [9:0]      w_sum_up;
    logic [9:0]      w_tgt_plus_step;
    logic [8:0]      w_lit_up;      // one step up, clamped at target
    logic [8:0]      w_lit_dn_tgt;  // one step down, clamped at target
    logic [8:0]      w_lit_dn_zero; // one step down, clamped at zero

    assign w_target = 9'(len_in_i) * 9'd100 + 9'(len_dec_i);
    assign w_en     = on_i && (power_level_i != 8'd0);
    assign w_tick   = (r_state != ST_OFF) && (r_tick_cnt == TW'(TICK_DIV - 1));

    // 10-bit arithmetic so lit + step can never wrap before the clamp.
    assign w_sum_up        = {1'b0, r_lit} + {1'b0, C_STEP};
    assign w_tgt_plus_step = {1'b0, w_target} + {1'b0, C_STEP};
    assign w_lit_up        = (w_sum_up >= {1'b0, w_target}) ? w_target : w_sum_up[8:0];
    assign w_lit_dn_tgt    = ({1'b0, r_lit} > w_tgt_plus_step) ? (r_lit - C_STEP) : w_target;
    assign w_lit_dn_zero   = (r_lit > C_STEP) ? (r_lit - C_STEP) : 9'd0;

    // ------------------------------------------------------------------------
    // Next-state, lit length, counters and colour
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_lit_nxt      = r_lit;
        w_tick_cnt_nxt = r_tick_cnt;
        w_flk_cnt_nxt  = '0;
        w_dim_nxt      = 1'b0;
        w_r_nxt        = 8'd0;
        w_g_nxt        = 8'd0;
        w_b_nxt        = 8'd0;

        case (r_state)
            ST_OFF: begin
                w_lit_nxt = 9'd0;
                if (w_en) begin
                    w_state_nxt = ST_IGNITE;
                end
            end
            ST_IGNITE: begin
                // Losing enable wins over any step on the same edge.
                if (!w_en) begin
                    w_state_nxt = ST_RETRACT;
                end else if (r_lit >= w_target) begin
                    w_state_nxt = ST_ON;
                    w_lit_nxt   = w_target;
                end else if (w_tick) begin
                    w_lit_nxt = w_lit_up;
                    if (w_lit_up == w_target) begin
                        w_state_nxt = ST_ON;
                    end
                end
            end
            ST_ON: begin
                // Live length edits are tracked here without leaving ON.
                if (!w_en) begin
                    w_state_nxt = ST_RETRACT;
                end else if (w_tick) begin
                    if (r_lit < w_target) begin
                        w_lit_nxt = w_lit_up;
                    end else if (r_lit > w_target) begin
                        w_lit_nxt = w_lit_dn_tgt;
                    end
                end
            end
            ST_RETRACT: begin
                if (w_en) begin
                    w_state_nxt = ST_IGNITE;
                end else if (w_tick) begin
                    w_lit_nxt = w_lit_dn_zero;
                    if (w_lit_dn_zero == 9'd0) begin
                        w_state_nxt = ST_OFF;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_OFF;
                w_lit_nxt   = 9'd0;
            end
        endcase

        // Tick phase restarts on every state change so each state's first
        // step lands a full TICK_DIV cycles after entry.
        if ((r_state == ST_OFF) || (w_state_nxt != r_state) || w_tick) begin
            w_tick_cnt_nxt = '0;
        end else begin
            w_tick_cnt_nxt = r_tick_cnt + 1'b1;
        end

        if ((r_state == ST_ON) && power_warn_i) begin
            if (r_flk_cnt == FW'(FLICKER_DIV - 1)) begin
                w_flk_cnt_nxt = '0;
                w_dim_nxt     = ~r_dim;
            end else begin
                w_flk_cnt_nxt = r_flk_cnt + 1'b1;
                w_dim_nxt     = r_dim;
            end
        end

        // Colour follows the inputs live; the dim value being registered on
        // this edge is used so dimming and un-dimming appear on the same edge.
        if (r_state != ST_OFF) begin
            w_r_nxt = w_dim_nxt ? {1'b0, r_i[7:1]} : r_i;
            w_g_nxt = w_dim_nxt ? {1'b0, g_i[7:1]} : g_i;
            w_b_nxt = w_dim_nxt ? {1'b0, b_i[7:1]} : b_i;
        end
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_OFF;
            r_lit      <= 9'd0;
            r_tick_cnt <= '0;
            r_flk_cnt  <= '0;
            r_dim      <= 1'b0;
            r_r        <= 8'd0;
            r_g        <= 8'd0;
            r_b        <= 8'd0;
            r_ready    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lit      <= w_lit_nxt;
            r_tick_cnt <= w_tick_cnt_nxt;
            r_flk_cnt  <= w_flk_cnt_nxt;
            r_dim      <= w_dim_nxt;
            r_r        <= w_r_nxt;
            r_g        <= w_g_nxt;
            r_b        <= w_b_nxt;
            r_ready    <= (w_state_nxt == ST_ON);
        end
    end

    assign lit_len_o = r_lit;
    assign r_o       = r_r;
    assign g_o       = r_g;
    assign b_o       = r_b;
    assign state_o   = r_state;
    assign ready_o   = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_blade_ignition_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_blade_ignition_seq
// Description : Self-checking bench for blade_ignition_seq. A table of
//               {inputs, edge count, expected outputs} records walks the
//               ignition, retraction, abort/resume, live length change and
//               power-loss scenarios; hand-written sequences cover flicker,
//               live colour change and asynchronous reset mid-climb.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_blade_ignition_seq;

    logic       clk;
    logic       rst;
    logic       on_i;
    logic [1:0] len_in_i;
    logic [5:0] len_dec_i;
    logic [7:0] r_i, g_i, b_i;
    logic [7:0] power_level_i;
    logic       power_warn_i;
    logic [8:0] lit_len_o;
    logic [7:0] r_o, g_o, b_o;
    logic [1:0] state_o;
    logic       ready_o;

    int n_cmp = 0;
    int n_bad = 0;

    blade_ignition_seq #(
        .STEP_CM    (8),
        .TICK_DIV   (4),
        .FLICKER_DIV(16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .on_i         (on_i),
        .len_in_i     (len_in_i),
        .len_dec_i    (len_dec_i),
        .r_i          (r_i),
        .g_i          (g_i),
        .b_i          (b_i),
        .power_level_i(power_level_i),
        .power_warn_i (power_warn_i),
        .lit_len_o    (lit_len_o),
        .r_o          (r_o),
        .g_o          (g_o),
        .b_o          (b_o),
        .state_o      (state_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic       on;
        logic [1:0] li;
        logic [5:0] ld;
        logic [7:0] pwr;
        int         n;      // rising edges to run before checking
        logic [8:0] lit;
        logic [1:0] st;
        logic       rdy;
        logic       col;    // 1: colour is (255,47,3), 0: colour is 0
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string nm, input logic rs, input logic on,
                       input logic [1:0] li, input logic [5:0] ld,
                       input logic [7:0] pwr, input int n, input logic [8:0] lit,
                       input logic [1:0] st, input logic rdy, input logic col);
        vec_t v;
        v.name = nm; v.rst = rs; v.on = on; v.li = li; v.ld = ld; v.pwr = pwr;
        v.n = n; v.lit = lit; v.st = st; v.rdy = rdy; v.col = col;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pack(input logic [8:0] lit, input logic [1:0] st,
                                         input logic rdy, input logic [7:0] r,
                                         input logic [7:0] g, input logic [7:0] b);
        return {28'd0, lit, st, rdy, r, g, b};
    endfunction

    initial begin
        logic [7:0] er, eg, eb;
        bit         dim;
        bit         got_on;

        rst = 1'b1; on_i = 1'b0; len_in_i = 2'd1; len_dec_i = 6'd50;
        r_i = 8'd255; g_i = 8'd47; b_i = 8'd3;
        power_level_i = 8'd200; power_warn_i = 1'b0;

        //   name            rst  on  li    ld     pwr    n    lit   st rdy col
        add("reset",         1, 0, 2'd1, 6'd50, 8'd200,   2, 9'd0,   0, 0, 0);
        add("off_to_ignite", 0, 1, 2'd1, 6'd50, 8'd200,   1, 9'd0,   1, 0, 0);
        add("first_tick",    0, 1, 2'd1, 6'd50, 8'd200,   4, 9'd8,   1, 0, 1);
        add("lit_144",       0, 1, 2'd1, 6'd50, 8'd200,  68, 9'd144, 1, 0, 1);
        add("pre_final",     0, 1, 2'd1, 6'd50, 8'd200,   3, 9'd144, 1, 0, 1);
        add("ignite_done",   0, 1, 2'd1, 6'd50, 8'd200,   1, 9'd150, 2, 1, 1);
        add("hold_on",       0, 1, 2'd1, 6'd50, 8'd200,   5, 9'd150, 2, 1, 1);
        add("retract_enter", 0, 0, 2'd1, 6'd50, 8'd200,   1, 9'd150, 3, 0, 1);
        add("retract_142",   0, 0, 2'd1, 6'd50, 8'd200,   4, 9'd142, 3, 0, 1);
        add("retract_6",     0, 0, 2'd1, 6'd50, 8'd200,  68, 9'd6,   3, 0, 1);
        add("retract_off",   0, 0, 2'd1, 6'd50, 8'd200,   4, 9'd0,   0, 0, 1);
        add("colour_off",    0, 0, 2'd1, 6'd50, 8'd200,   1, 9'd0,   0, 0, 0);
        add("reignite",      0, 1, 2'd1, 6'd50, 8'd200,   1, 9'd0,   1, 0, 0);
        add("lit_64",        0, 1, 2'd1, 6'd50, 8'd200,  32, 9'd64,  1, 0, 1);
        add("abort",         0, 0, 2'd1, 6'd50, 8'd200,   1, 9'd64,  3, 0, 1);
        add("abort_56",      0, 0, 2'd1, 6'd50, 8'd200,   4, 9'd56,  3, 0, 1);
        add("abort_48",      0, 0, 2'd1, 6'd50, 8'd200,   4, 9'd48,  3, 0, 1);
        add("resume",        0, 1, 2'd1, 6'd50, 8'd200,   1, 9'd48,  1, 0, 1);
        add("resume_56",     0, 1, 2'd1, 6'd50, 8'd200,   4, 9'd56,  1, 0, 1);
        add("resume_144",    0, 1, 2'd1, 6'd50, 8'd200,  44, 9'd144, 1, 0, 1);
        add("resume_on",     0, 1, 2'd1, 6'd50, 8'd200,   4, 9'd150, 2, 1, 1);
        add("live_158",      0, 1, 2'd2, 6'd33, 8'd200,   4, 9'd158, 2, 1, 1);
        add("live_230",      0, 1, 2'd2, 6'd33, 8'd200,  36, 9'd230, 2, 1, 1);
        add("live_233",      0, 1, 2'd2, 6'd33, 8'd200,   4, 9'd233, 2, 1, 1);
        add("pwr_loss",      0, 1, 2'd2, 6'd33, 8'd0,     1, 9'd233, 3, 0, 1);
        add("pwr_1",         0, 1, 2'd2, 6'd33, 8'd0,   116, 9'd1,   3, 0, 1);
        add("pwr_off",       0, 1, 2'd2, 6'd33, 8'd0,     4, 9'd0,   0, 0, 1);
        add("pwr_col",       0, 1, 2'd2, 6'd33, 8'd0,     1, 9'd0,   0, 0, 0);
        add("pwr_hold",      0, 1, 2'd2, 6'd33, 8'd0,     5, 9'd0,   0, 0, 0);

        #1;
        foreach (vecs[i]) begin
            rst = vecs[i].rst; on_i = vecs[i].on;
            len_in_i = vecs[i].li; len_dec_i = vecs[i].ld;
            power_level_i = vecs[i].pwr;
            step(vecs[i].n);
            er = vecs[i].col ? 8'd255 : 8'd0;
            eg = vecs[i].col ? 8'd47  : 8'd0;
            eb = vecs[i].col ? 8'd3   : 8'd0;
            check(vecs[i].name, pack(lit_len_o, state_o, ready_o, r_o, g_o, b_o),
                  pack(vecs[i].lit, vecs[i].st, vecs[i].rdy, er, eg, eb));
        end

        // Flicker: ignite to a short 16 cm blade, then raise the warning.
        power_level_i = 8'd200; len_in_i = 2'd0; len_dec_i = 6'd16; on_i = 1'b1;
        got_on = 1'b0;
        for (int c = 0; c < 40 && !got_on; c++) begin
            step(1);
            if (state_o == 2'd2) got_on = 1'b1;
        end
        check("flk_reach_on", {55'd0, got_on, lit_len_o}, {55'd0, 1'b1, 9'd16});

        power_warn_i = 1'b1;
        for (int i = 1; i <= 48; i++) begin
            step(1);
            dim = ((i / 16) % 2) == 1;
            er = dim ? 8'd127 : 8'd255;
            eg = dim ? 8'd23  : 8'd47;
            eb = dim ? 8'd1   : 8'd3;
            check($sformatf("flicker_%0d", i), {40'd0, r_o, g_o, b_o}, {40'd0, er, eg, eb});
        end
        power_warn_i = 1'b0;
        step(1);
        check("flk_clear", {40'd0, r_o, g_o, b_o}, {40'd0, 8'd255, 8'd47, 8'd3});

        // Colour is not latched: new inputs appear one edge later.
        r_i = 8'd10; g_i = 8'd20; b_i = 8'd30;
        step(1);
        check("live_colour", {40'd0, r_o, g_o, b_o}, {40'd0, 8'd10, 8'd20, 8'd30});

        // Live length change: exactly two ticks fall in any 8 ON cycles.
        len_in_i = 2'd2; len_dec_i = 6'd33;
        step(8);
        check("climb_32", pack(lit_len_o, state_o, ready_o, r_o, g_o, b_o),
              pack(9'd32, 2'd2, 1'b1, 8'd10, 8'd20, 8'd30));

        // Asynchronous reset mid-cycle: outputs clear before the next edge.
        #2 rst = 1'b1;
        #1;
        check("async_reset", pack(lit_len_o, state_o, ready_o, r_o, g_o, b_o),
              pack(9'd0, 2'd0, 1'b0, 8'd0, 8'd0, 8'd0));

        @(posedge clk);
        #1 rst = 1'b0; on_i = 1'b0;
        step(2);
        check("post_reset_off", pack(lit_len_o, state_o, ready_o, r_o, g_o, b_o),
              pack(9'd0, 2'd0, 1'b0, 8'd0, 8'd0, 8'd0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
